// File: rtl/gray_pkg.sv
// Purpose: shared Gray/binary conversion helpers and width limits for the Gray counter.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package gray_pkg;

   // Legal counter widths; the conversion helpers operate on the widest legal word.
   localparam int GRAY_WIDTH_MIN = 2;
   localparam int GRAY_WIDTH_MAX = 16;

   typedef logic [GRAY_WIDTH_MAX-1:0] gray_word_t;

   // Per-edge action chosen by the counter after control priority is resolved.
   typedef enum logic [1:0] {
      STEP_NONE = 2'd0,
      STEP_UP   = 2'd1,
      STEP_DOWN = 2'd2,
      STEP_LOAD = 2'd3
   } step_e;

   // Binary to reflected Gray: each Gray bit is the XOR of adjacent binary bits.
   function automatic gray_word_t bin2gray(input gray_word_t bin);
      return bin ^ (bin >> 1);
   endfunction

   // Reflected Gray to binary: running XOR from the MSB downwards.
   // Narrower values are zero-extended, so the upper zeros do not disturb the result.
   function automatic gray_word_t gray2bin(input gray_word_t gray);
      gray_word_t bin;
      bin[GRAY_WIDTH_MAX-1] = gray[GRAY_WIDTH_MAX-1];
      for (int i = GRAY_WIDTH_MAX - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray_encode.sv
// Purpose: combinational binary-to-Gray encoder, WIDTH bits wide.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows input continuously.
module gray_encode
   import gray_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] bin_i,
   output logic [WIDTH-1:0] gray_o
);

   // Widen to the package word, convert, and keep only the low WIDTH bits.
   assign gray_o = WIDTH'(bin2gray(gray_word_t'(bin_i)));

endmodule

// File: rtl/gray_counter.sv
// Purpose: up/down Gray counter with load, optional saturation, sticky over/underflow and a wrap pulse.
// Latency: outputs registered; a control applied before an edge is visible right after that edge.
// Backpressure: none; one step per enabled cycle, Load overrides En, Reset overrides all.
module gray_counter
   import gray_pkg::*;
#(
   parameter int WIDTH    = 3,   // legal range GRAY_WIDTH_MIN..GRAY_WIDTH_MAX
   parameter int SATURATE = 0    // 0 = wrap at the ends, 1 = hold at the terminal value
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             En,
   input  logic             Dir,
   input  logic             Load,
   input  logic [WIDTH-1:0] LoadVal,
   input  logic             Clear,
   output logic [WIDTH-1:0] Output,
   output logic [WIDTH-1:0] BinOut,
   output logic             Overflow,
   output logic             Underflow,
   output logic             Wrap
);

   localparam logic [WIDTH-1:0] BIN_MAX = '1;
   localparam logic [WIDTH-1:0] BIN_MIN = '0;
   localparam logic [WIDTH-1:0] BIN_ONE = WIDTH'(1);

   // The count lives in binary; Gray is always derived from it so the two cannot disagree.
   logic [WIDTH-1:0] bin_q = '0;
   logic [WIDTH-1:0] bin_d;
   logic             ovf_q = 1'b0;
   logic             ovf_d;
   logic             unf_q = 1'b0;
   logic             unf_d;
   logic             wrap_q = 1'b0;
   logic             wrap_d;

   step_e            step;
   logic             ovf_set;
   logic             unf_set;

   // Resolve control priority: Load beats En, and Dir only matters for an enabled step.
   always_comb begin
      step = STEP_NONE;
      if (Load) begin
         step = STEP_LOAD;
      end else if (En) begin
         step = Dir ? STEP_DOWN : STEP_UP;
      end
   end

   // Next count, terminal detection and wrap pulse for the resolved step.
   always_comb begin
      bin_d   = bin_q;
      wrap_d  = 1'b0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      case (step)
         STEP_LOAD: begin
            bin_d = LoadVal;
         end
         STEP_UP: begin
            if (bin_q == BIN_MAX) begin
               ovf_set = 1'b1;
               if (SATURATE == 0) begin
                  bin_d  = BIN_MIN;
                  wrap_d = 1'b1;
               end
            end else begin
               bin_d = bin_q + BIN_ONE;
            end
         end
         STEP_DOWN: begin
            if (bin_q == BIN_MIN) begin
               unf_set = 1'b1;
               if (SATURATE == 0) begin
                  bin_d  = BIN_MAX;
                  wrap_d = 1'b1;
               end
            end else begin
               bin_d = bin_q - BIN_ONE;
            end
         end
         default: begin
            bin_d = bin_q;
         end
      endcase
   end

   // Sticky flags: a new set event on this edge wins over Clear.
   always_comb begin
      ovf_d = ovf_set | (ovf_q & ~Clear);
      unf_d = unf_set | (unf_q & ~Clear);
   end

   // State registers with synchronous reset taking precedence over every other control.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         bin_q  <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         ovf_q  <= ovf_d;
         unf_q  <= unf_d;
         wrap_q <= wrap_d;
      end
   end

   gray_encode #(
      .WIDTH (WIDTH)
   ) u_gray_encode (
      .bin_i  (bin_q),
      .gray_o (Output)
   );

   assign BinOut    = bin_q;
   assign Overflow  = ovf_q;
   assign Underflow = unf_q;
   assign Wrap      = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Purpose: directed self-checking bench for gray_counter (wrapping and saturating instances).
// Latency: expectations are queued with each stimulus step and compared #1 after the edge.
// Backpressure: not applicable.
module tb_gray_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: WIDTH=3, wrapping
   logic       a_reset, a_en, a_dir, a_load, a_clear;
   logic [2:0] a_loadval;
   logic [2:0] a_gray, a_bin;
   logic       a_ovf, a_unf, a_wrap;

   // Instance B: WIDTH=3, saturating
   logic       b_reset, b_en, b_dir, b_load, b_clear;
   logic [2:0] b_loadval;
   logic [2:0] b_gray, b_bin;
   logic       b_ovf, b_unf, b_wrap;

   gray_counter #(.WIDTH(3), .SATURATE(0)) dut_wrap (
      .Clk       (clk),
      .Reset     (a_reset),
      .En        (a_en),
      .Dir       (a_dir),
      .Load      (a_load),
      .LoadVal   (a_loadval),
      .Clear     (a_clear),
      .Output    (a_gray),
      .BinOut    (a_bin),
      .Overflow  (a_ovf),
      .Underflow (a_unf),
      .Wrap      (a_wrap)
   );

   gray_counter #(.WIDTH(3), .SATURATE(1)) dut_sat (
      .Clk       (clk),
      .Reset     (b_reset),
      .En        (b_en),
      .Dir       (b_dir),
      .Load      (b_load),
      .LoadVal   (b_loadval),
      .Clear     (b_clear),
      .Output    (b_gray),
      .BinOut    (b_bin),
      .Overflow  (b_ovf),
      .Underflow (b_unf),
      .Wrap      (b_wrap)
   );

   typedef struct packed {
      logic       sel;   // 0 = instance A, 1 = instance B
      logic [2:0] bin;
      logic [2:0] gray;
      logic       ovf;
      logic       unf;
      logic       wrap;
   } exp_t;

   exp_t  sb_q[$];
   string tag_q[$];
   int    checks = 0;
   int    errors = 0;

   logic [2:0] up_gray [8] = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd0};

   task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic sel, input logic [2:0] bin,
                             input logic [2:0] gray, input logic ovf, input logic unf,
                             input logic wrap);
      exp_t e;
      e.sel  = sel;
      e.bin  = bin;
      e.gray = gray;
      e.ovf  = ovf;
      e.unf  = unf;
      e.wrap = wrap;
      sb_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      exp_t       e;
      string      t;
      logic [2:0] o_bin, o_gray;
      logic       o_ovf, o_unf, o_wrap;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         t = tag_q.pop_front();
         if (e.sel == 1'b0) begin
            o_bin = a_bin; o_gray = a_gray; o_ovf = a_ovf; o_unf = a_unf; o_wrap = a_wrap;
         end else begin
            o_bin = b_bin; o_gray = b_gray; o_ovf = b_ovf; o_unf = b_unf; o_wrap = b_wrap;
         end
         chk({t, ".bin"},  o_bin,      e.bin);
         chk({t, ".gray"}, o_gray,     e.gray);
         chk({t, ".ovf"},  3'(o_ovf),  3'(e.ovf));
         chk({t, ".unf"},  3'(o_unf),  3'(e.unf));
         chk({t, ".wrap"}, 3'(o_wrap), 3'(e.wrap));
      end
   endtask

   initial begin
      a_reset = 1'b1; a_en = 1'b0; a_dir = 1'b0; a_load = 1'b0; a_clear = 1'b0; a_loadval = 3'd0;
      b_reset = 1'b1; b_en = 1'b0; b_dir = 1'b0; b_load = 1'b0; b_clear = 1'b0; b_loadval = 3'd0;

      // Reset state of both instances
      expect_out("rst_a", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      expect_out("rst_b", 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      tick(); drain();
      a_reset = 1'b0; b_reset = 1'b0;

      // Eight up steps from 0: full Gray cycle, overflow + wrap on the eighth
      a_en = 1'b1; a_dir = 1'b0;
      for (int i = 0; i < 8; i++) begin
         expect_out($sformatf("up%0d", i), 1'b0, 3'((i + 1) % 8), up_gray[i],
                    (i == 7), 1'b0, (i == 7));
         tick(); drain();
      end

      // Idle with Dir toggled: everything holds, wrap drops
      a_en = 1'b0; a_dir = 1'b1;
      expect_out("hold", 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
      tick(); drain();

      // Reset beats an enabled step and clears the sticky flag
      a_reset = 1'b1; a_en = 1'b1;
      expect_out("rst_mid", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      tick(); drain();
      a_reset = 1'b0;

      // One down step from 0 wraps to 7
      a_dir = 1'b1; a_en = 1'b1;
      expect_out("dn_wrap", 1'b0, 3'd7, 3'd4, 1'b0, 1'b1, 1'b1);
      tick(); drain();

      // Load beats En; flags unchanged; wrap low
      a_load = 1'b1; a_loadval = 3'd5;
      expect_out("load5", 1'b0, 3'd5, 3'd7, 1'b0, 1'b1, 1'b0);
      tick(); drain();

      // Back-to-back non-wrapping down step keeps wrap low
      a_load = 1'b0;
      expect_out("dn_b2b", 1'b0, 3'd4, 3'd6, 1'b0, 1'b1, 1'b0);
      tick(); drain();

      // Clear alone drops underflow
      a_en = 1'b0; a_clear = 1'b1;
      expect_out("clr_unf", 1'b0, 3'd4, 3'd6, 1'b0, 1'b0, 1'b0);
      tick(); drain();

      // Load 7, then Clear together with an overflow step: set wins
      a_clear = 1'b0; a_load = 1'b1; a_loadval = 3'd7;
      expect_out("load7", 1'b0, 3'd7, 3'd4, 1'b0, 1'b0, 1'b0);
      tick(); drain();
      a_load = 1'b0; a_en = 1'b1; a_dir = 1'b0; a_clear = 1'b1;
      expect_out("clr_vs_ovf", 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1);
      tick(); drain();
      a_en = 1'b0;
      expect_out("clr_ovf", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      tick(); drain();

      // Reset while BinOut=6 and Load is high
      a_clear = 1'b0; a_load = 1'b1; a_loadval = 3'd6;
      expect_out("load6", 1'b0, 3'd6, 3'd5, 1'b0, 1'b0, 1'b0);
      tick(); drain();
      a_reset = 1'b1; a_loadval = 3'd3; a_en = 1'b1;
      expect_out("rst_load", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      tick(); drain();
      a_reset = 1'b0; a_load = 1'b0; a_dir = 1'b0;
      expect_out("post_rst", 1'b0, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0);
      tick(); drain();
      expect_out("up_b2b", 1'b0, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0);
      tick(); drain();
      a_en = 1'b0;

      // Saturating instance: hold at 7 for three up steps
      b_load = 1'b1; b_loadval = 3'd7;
      expect_out("b_load7", 1'b1, 3'd7, 3'd4, 1'b0, 1'b0, 1'b0);
      tick(); drain();
      b_load = 1'b0; b_en = 1'b1; b_dir = 1'b0;
      for (int i = 0; i < 3; i++) begin
         expect_out($sformatf("b_sat%0d", i), 1'b1, 3'd7, 3'd4, 1'b1, 1'b0, 1'b0);
         tick(); drain();
      end

      // Saturating down step from 0 holds and sets underflow only
      b_en = 1'b0; b_load = 1'b1; b_loadval = 3'd0;
      expect_out("b_load0", 1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
      tick(); drain();
      b_load = 1'b0; b_en = 1'b1; b_dir = 1'b1;
      expect_out("b_satdn", 1'b1, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
      tick(); drain();
      b_en = 1'b0; b_clear = 1'b1;
      expect_out("b_clr", 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      tick(); drain();
      b_clear = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
